// File: rtl/vga_framebuffer.sv
// Dual-port pixel store feeding the VGA driver: registered display read, handshaked write port,
// and a whole-buffer clear engine. Define FB_VBLANK_CLEAR_EN to restrict clear writes to vis=0 cycles.
module vga_framebuffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              vis,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [DATA_W-1:0] clr_color_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              wr_ready_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              clr_adv_s;
    logic              clr_last_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

`ifdef FB_VBLANK_CLEAR_EN
    // Only touch memory while the beam is outside the visible area.
    assign clr_adv_s = ~vis;
`else
    logic unused_vis_s;
    assign unused_vis_s = vis;
    assign clr_adv_s    = 1'b1;
`endif

    // End of fill is the all-ones pointer, so the pointer itself can wrap cleanly to zero.
    assign clr_last_s = (clr_ptr_r == {ADDR_W{1'b1}});

    // Single memory write port shared by the clear engine and the host writer.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (!rst_n) begin
            mem_we_s = 1'b0;
        end else if (state_r == CLEAR) begin
            if (clr_adv_s) begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_r;
                mem_wdata_s = clr_color_r;
            end else begin
                mem_we_s = 1'b0;
            end
        end else if (wr_en && wr_ready_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Pixel array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Display read: one-cycle latency, old data on a same-address write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    // Clear engine sequencing with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            clr_ptr_r   <= {ADDR_W{1'b0}};
            clr_color_r <= {DATA_W{1'b0}};
            wr_ready_r  <= 1'b1;
            clr_busy_r  <= 1'b0;
            clr_done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        state_r     <= CLEAR;
                        clr_ptr_r   <= {ADDR_W{1'b0}};
                        clr_color_r <= clr_color;
                        wr_ready_r  <= 1'b0;
                        clr_busy_r  <= 1'b1;
                    end else begin
                        wr_ready_r <= 1'b1;
                        clr_busy_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_adv_s) begin
                        clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (clr_last_s) begin
                            state_r    <= DONE;
                            wr_ready_r <= 1'b1;
                            clr_busy_r <= 1'b0;
                            clr_done_r <= 1'b1;
                        end else begin
                            state_r <= CLEAR;
                        end
                    end else begin
                        state_r <= CLEAR;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    wr_ready_r <= 1'b1;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    wr_ready_r <= 1'b1;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_r;
    assign wr_ready = wr_ready_r;
    assign clr_busy = clr_busy_r;
    assign clr_done = clr_done_r;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench for vga_framebuffer: a 16-bit instance for read/write timing and a
// 4-bit instance for the clear engine (busy length, done pulse, contention, abort, vis gating).
module tb_vga_framebuffer;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic [15:0] b_rd_addr, b_wr_addr;
    logic [7:0]  b_rd_data, b_wr_data, b_clr_color;
    logic        b_vis, b_wr_en, b_wr_ready, b_clr_start, b_clr_busy, b_clr_done;
    logic [3:0]  s_rd_addr, s_wr_addr;
    logic [7:0]  s_rd_data, s_wr_data, s_clr_color;
    logic        s_vis, s_wr_en, s_wr_ready, s_clr_start, s_clr_busy, s_clr_done;

    vga_framebuffer u_big (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .vis(b_vis),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .clr_start(b_clr_start), .clr_color(b_clr_color), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    vga_framebuffer #(.ADDR_W(4), .DATA_W(8)) u_small (
        .clk(clk), .rst_n(rst_n), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .vis(s_vis),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .clr_start(s_clr_start), .clr_color(s_clr_color), .clr_busy(s_clr_busy), .clr_done(s_clr_done)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t b_q[$];
    exp_t s_q[$];
    logic b_req = 1'b0, s_req = 1'b0, b_vld = 1'b0, s_vld = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A read issued before a posedge produces data valid after that posedge.
    always @(posedge clk) begin
        b_vld <= b_req;
        s_vld <= s_req;
    end

    // Monitor: pop the expected pixel whenever a read result is due.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (b_vld) begin
            if (b_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL big_rd_unexpected: got %0h expected none", b_rd_data);
            end else begin
                e = b_q.pop_front();
                chk($sformatf("big_rd@%0h", e.addr), {24'h0, b_rd_data}, {24'h0, e.data});
            end
        end
        if (s_vld) begin
            if (s_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL small_rd_unexpected: got %0h expected none", s_rd_data);
            end else begin
                e = s_q.pop_front();
                chk($sformatf("small_rd@%0h", e.addr), {24'h0, s_rd_data}, {24'h0, e.data});
            end
        end
    end

    task automatic wr_big(input logic [15:0] a, input logic [7:0] d);
        b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d;
        @(negedge clk);
        b_wr_en = 1'b0;
    endtask

    task automatic rd_big(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        b_rd_addr = a; b_req = 1'b1; e.addr = a; e.data = d; b_q.push_back(e);
        @(negedge clk);
        b_req = 1'b0;
    endtask

    task automatic rd_small(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        s_rd_addr = a; s_req = 1'b1; e.addr = {12'h000, a}; e.data = d; s_q.push_back(e);
        @(negedge clk);
        s_req = 1'b0;
    endtask

    // mode 0 plain, 1 contention, 2 vis toggling; abort_at >= 0 leaves the loop early.
    task automatic run_clear(input logic [7:0] color, input int mode, input int abort_at,
                             output int busy_cnt, output int clk_cnt, output bit done_seen);
        int c;
        s_clr_color = color; s_clr_start = 1'b1;
        @(negedge clk);
        s_clr_start = 1'b0;
        busy_cnt = 0; clk_cnt = 0; done_seen = 1'b0; c = 0;
        while (!done_seen && c < 100) begin
            if (c == abort_at) break;
            if (s_clr_done) begin
                done_seen = 1'b1;
            end else begin
                clk_cnt++;
                if (s_clr_busy) begin
                    busy_cnt++;
                    chk("wr_ready_in_clear", {31'h0, s_wr_ready}, 32'h0);
                end
                if (mode == 1) begin
                    if (c >= 1 && c <= 4) begin
                        s_wr_en = 1'b1; s_wr_addr = 4'h0; s_wr_data = 8'h55;
                    end else if (c >= 9) begin
                        s_wr_en = 1'b1; s_wr_addr = 4'h5; s_wr_data = 8'h99;
                    end else begin
                        s_wr_en = 1'b0;
                    end
                    s_clr_start = (c == 6);
                    if (c == 6) s_clr_color = 8'hEE;
                end else if (mode == 2) begin
                    s_vis = (c % 2 == 0);
                end
                @(negedge clk);
                c++;
            end
        end
        if (done_seen) begin
            chk("done_wr_ready", {31'h0, s_wr_ready}, 32'h1);
            chk("done_busy_low", {31'h0, s_clr_busy}, 32'h0);
            @(negedge clk);
            chk("done_one_cycle", {31'h0, s_clr_done}, 32'h0);
        end
        s_wr_en = 1'b0; s_vis = 1'b0; s_clr_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc, cc, exp_cc;
        bit  dn;
        rst_n = 1'b0;
        b_rd_addr = 16'h0; b_wr_addr = 16'h0; b_wr_data = 8'h0; b_clr_color = 8'h0;
        b_vis = 1'b0; b_wr_en = 1'b0; b_clr_start = 1'b0;
        s_rd_addr = 4'h0; s_wr_addr = 4'h0; s_wr_data = 8'h0; s_clr_color = 8'h0;
        s_vis = 1'b0; s_wr_en = 1'b0; s_clr_start = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_rd_data", {24'h0, b_rd_data}, 32'h0);
        chk("rst_wr_ready", {31'h0, b_wr_ready}, 32'h1);
        chk("rst_busy", {31'h0, b_clr_busy}, 32'h0);
        chk("rst_done", {31'h0, b_clr_done}, 32'h0);
        chk("rst_small_rd_data", {24'h0, s_rd_data}, 32'h0);
        chk("rst_small_busy", {31'h0, s_clr_busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read, same-cycle read/write returns old data
        wr_big(16'h1234, 8'hA5);
        rd_big(16'h1234, 8'hA5);
        b_wr_en = 1'b1; b_wr_addr = 16'h1234; b_wr_data = 8'h3C;
        rd_big(16'h1234, 8'hA5);
        b_wr_en = 1'b0;
        rd_big(16'h1234, 8'h3C);
        wr_big(16'hFFFF, 8'h0F);
        wr_big(16'h0000, 8'hF0);
        rd_big(16'hFFFF, 8'h0F);
        rd_big(16'h0000, 8'hF0);
        rd_big(16'h1234, 8'h3C);

        // Clear fill
        run_clear(8'h7E, 0, -1, bc, cc, dn);
        chk("clear_done_seen", {31'h0, dn}, 32'h1);
        chk("clear_busy_cycles", bc, 32'd16);
        for (int i = 0; i < 16; i++) rd_small(i[3:0], 8'h7E);

        // Contention: writes blocked during clear, held write taken in DONE, restart ignored
        run_clear(8'h11, 1, -1, bc, cc, dn);
        chk("contend_done_seen", {31'h0, dn}, 32'h1);
        chk("contend_busy_cycles", bc, 32'd16);
        rd_small(4'h0, 8'h11);
        rd_small(4'h5, 8'h99);
        rd_small(4'h7, 8'h11);
        rd_small(4'hF, 8'h11);

        // vis gating
        run_clear(8'h5A, 2, -1, bc, cc, dn);
`ifdef FB_VBLANK_CLEAR_EN
        exp_cc = 32;
`else
        exp_cc = 16;
`endif
        chk("vis_done_seen", {31'h0, dn}, 32'h1);
        chk("vis_clear_cycles", cc, exp_cc);
        rd_small(4'h0, 8'h5A);
        rd_small(4'hF, 8'h5A);

        // Abort by reset after five clear writes
        run_clear(8'h22, 0, -1, bc, cc, dn);
        chk("prefill_done_seen", {31'h0, dn}, 32'h1);
        run_clear(8'h33, 0, 5, bc, cc, dn);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, s_clr_busy}, 32'h0);
        chk("abort_done", {31'h0, s_clr_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, s_clr_done}, 32'h0);
        end
        chk("abort_idle_ready", {31'h0, s_wr_ready}, 32'h1);
        for (int i = 0; i < 16; i++) rd_small(i[3:0], (i < 5) ? 8'h33 : 8'h22);

        repeat (3) @(negedge clk);
        chk("sb_big_drained", b_q.size(), 32'h0);
        chk("sb_small_drained", s_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
